btn_pulse_ctrl: RTL
===================

BTN_PULSE_CTRL -- requirements
Module: btn_pulse_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 500000: consecutive stable samples required to accept a button level change.
REQ-002 Parameter CNT_W, default 20: width of each debounce counter; must satisfy 2**CNT_W > DB_CYCLES.
REQ-003 Parameters REPEAT_DELAY, default 50000000, and REPEAT_PERIOD, default 10000000: auto-repeat timing, used only when BTN_AUTOREPEAT_EN is defined.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 btn_up  input  1  raw, asynchronous, bouncy "count up" button; 1 = pressed.
REQ-007 btn_dn  input  1  raw, asynchronous, bouncy "count down" button; 1 = pressed.
REQ-008 PED  output  1  registered single-cycle step pulse for the up/down counter.
REQ-009 uphdnl  output  1  registered direction; 1 = up, 0 = down; valid whenever PED = 1.

Function
REQ-010 Each raw input shall pass through a 2-flop synchronizer before any other logic.
REQ-011 Each button shall have its own debouncer with states IDLE, PRESS_CHK, HELD and RELEASE_CHK.
REQ-012 Debouncer transitions: IDLE -> PRESS_CHK when sync = 1; PRESS_CHK -> HELD after DB_CYCLES consecutive sync = 1; PRESS_CHK -> IDLE on any sync = 0.
REQ-013 Debouncer transitions: HELD -> RELEASE_CHK when sync = 0; RELEASE_CHK -> IDLE after DB_CYCLES consecutive sync = 0; RELEASE_CHK -> HELD on any sync = 1.
REQ-014 Each debouncer counter shall clear on every state entry and must not wrap.
REQ-015 A debouncer shall emit a one-cycle press event on the PRESS_CHK -> HELD transition only; release generates no event.
REQ-016 PED shall be 1 for exactly the cycle after a press event and 0 in all other cycles, giving a latency of DB_CYCLES+3 clocks from the first clk edge sampling raw = 1.
REQ-017 uphdnl shall load 1 for an up event or 0 for a down event in the same cycle PED asserts, and shall hold that value otherwise.
REQ-018 If up and down press events occur in the same cycle, both shall be discarded: PED stays 0 and uphdnl is unchanged.
REQ-019 A press of one button while the other is in HELD shall still produce its own pulse.
REQ-020 PED shall never be high in two consecutive cycles.

Reset
REQ-021 reset = 0 shall immediately force PED = 0, uphdnl = 1, all synchronizer flops to 0, all debouncers to IDLE and all counters to 0, independent of clk.
REQ-022 Reset asserted mid-debounce shall abandon the debounce without emitting a pulse.
REQ-023 After reset release, a button already held shall be treated as a new press, producing one pulse after DB_CYCLES+3 clocks.

Configuration
REQ-024 Macro BTN_AUTOREPEAT_EN, when defined, shall make a debouncer in HELD emit an additional press event after REPEAT_DELAY cycles in HELD, then every REPEAT_PERIOD cycles until it leaves HELD.
REQ-025 Without BTN_AUTOREPEAT_EN, exactly one pulse shall be produced per debounced press, and no repeat counter logic shall be synthesized.

Structure
REQ-026 Package btn_pulse_pkg shall hold the debouncer state enum typedef and the default DB_CYCLES, REPEAT_DELAY and REPEAT_PERIOD constants.
REQ-027 Sub-module btn_debounce (synchronizer, FSM, counter and optional repeat) shall be instantiated twice; the top level holds arbitration and the output registers.

Verification (DB_CYCLES = 4, REPEAT_DELAY = 20, REPEAT_PERIOD = 8 for the bench)
REQ-028 Clean btn_up press held for 30 cycles -> one PED pulse with uphdnl = 1, 7 clocks after the press; no further pulses (macro off).
REQ-029 btn_dn toggling every 2 cycles for 20 cycles, then held high -> no PED during the bounce; one pulse with uphdnl = 0 after the level settles.
REQ-030 btn_up and btn_dn rising on the same edge and held -> PED stays 0; uphdnl stays at its previous value.
REQ-031 reset = 0 pulsed 2 cycles into PRESS_CHK while btn_up is held -> PED = 0 and uphdnl = 1 immediately; one pulse 7 clocks after reset release.
REQ-032 With BTN_AUTOREPEAT_EN, btn_up held for 60 cycles -> pulses at press+7, +27, +35, +43, +51, +59.
REQ-033 btn_up held, then btn_dn pressed -> a second pulse with uphdnl = 0, and PED never high in two consecutive cycles.

Source files
------------

// File: rtl/btn_pulse_pkg.sv
// btn_pulse_pkg: shared types and default timing constants for the button
// pulse controller. Optional auto-repeat is enabled by defining BTN_AUTOREPEAT_EN.
package btn_pulse_pkg;

  // Debouncer FSM states
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } db_state_t;

  // Default timing in clk cycles
  localparam int DEF_DB_CYCLES     = 500000;
  localparam int DEF_CNT_W         = 20;
  localparam int DEF_REPEAT_DELAY  = 50000000;
  localparam int DEF_REPEAT_PERIOD = 10000000;

  // Counter width able to hold 0 .. max(a, b) - 1
  function automatic int rpt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer followed by a four-state debounce FSM.
// Emits a registered one-cycle press_evt when a press is accepted.
// With BTN_AUTOREPEAT_EN defined, a held button also emits repeat events
// after REPEAT_DELAY cycles in HELD and then every REPEAT_PERIOD cycles.
module btn_debounce
  import btn_pulse_pkg::*;
#(
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press_evt
);

  // Last count value of a debounce window; the counter never goes past it
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic      sync_1_reg;
  logic      sync_2_reg;
  db_state_t state_reg;
  logic [CNT_W-1:0] cnt_reg;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_W = rpt_width(REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [RPT_W-1:0] RPT_FIRST_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_NEXT_LAST  = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt_reg;
  logic             rpt_armed_reg;  // first repeat already issued in this hold
`endif

  // Two-flop synchronizer for the raw asynchronous button level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1_reg <= 1'b0;
      sync_2_reg <= 1'b0;
    end else begin
      sync_1_reg <= raw;
      sync_2_reg <= sync_1_reg;
    end
  end

  // Debounce FSM with stability counter and registered press event
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      press_evt <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rpt_cnt_reg   <= '0;
      rpt_armed_reg <= 1'b0;
`endif
    end else begin
      press_evt <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (sync_2_reg) begin
            state_reg <= PRESS_CHK;
            cnt_reg   <= '0;
          end
        end
        PRESS_CHK: begin
          if (!sync_2_reg) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (cnt_reg == DB_LAST) begin
            state_reg <= HELD;
            cnt_reg   <= '0;
            press_evt <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
            rpt_cnt_reg   <= '0;
            rpt_armed_reg <= 1'b0;
`endif
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        HELD: begin
          if (!sync_2_reg) begin
            state_reg <= RELEASE_CHK;
            cnt_reg   <= '0;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (rpt_cnt_reg == (rpt_armed_reg ? RPT_NEXT_LAST : RPT_FIRST_LAST)) begin
            press_evt     <= 1'b1;
            rpt_cnt_reg   <= '0;
            rpt_armed_reg <= 1'b1;
          end else begin
            rpt_cnt_reg <= rpt_cnt_reg + 1'b1;
          end
`endif
        end
        RELEASE_CHK: begin
          if (sync_2_reg) begin
            // Release bounce: back to HELD, repeat timing restarts
            state_reg <= HELD;
            cnt_reg   <= '0;
`ifdef BTN_AUTOREPEAT_EN
            rpt_cnt_reg   <= '0;
            rpt_armed_reg <= 1'b0;
`endif
          end else if (cnt_reg == DB_LAST) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_pulse_ctrl.sv
// btn_pulse_ctrl: two debounced buttons (up/down) turned into a single-cycle
// step pulse PED with a direction flag uphdnl for an up/down counter.
// Simultaneous up/down events cancel. An event arriving while PED is high is
// held one cycle so PED is never high in two consecutive cycles.
// Auto-repeat is enabled by defining BTN_AUTOREPEAT_EN.
module btn_pulse_ctrl
  import btn_pulse_pkg::*;
#(
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_dn,
  output logic PED,
  output logic uphdnl
);

  // Index 0 = up button, index 1 = down button
  logic [1:0] raw_btn;
  logic [1:0] press_evt;
  logic       single_evt;
  logic       single_dir;

  logic ped_reg;
  logic dir_reg;
  logic pend_reg;
  logic pend_dir_reg;

  assign raw_btn = {btn_dn, btn_up};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      btn_debounce #(
        .DB_CYCLES     (DB_CYCLES),
        .CNT_W         (CNT_W),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_db (
        .clk       (clk),
        .reset     (reset),
        .raw       (raw_btn[gi]),
        .press_evt (press_evt[gi])
      );
    end
  endgenerate

  // Exactly one button reporting a press; both at once is discarded
  assign single_evt = press_evt[0] ^ press_evt[1];
  assign single_dir = press_evt[0];

  // Output pulse and direction registers with one-deep deferral slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ped_reg      <= 1'b0;
      dir_reg      <= 1'b1;
      pend_reg     <= 1'b0;
      pend_dir_reg <= 1'b1;
    end else if (ped_reg) begin
      ped_reg <= 1'b0;
      if (single_evt) begin
        pend_reg     <= 1'b1;
        pend_dir_reg <= single_dir;
      end
    end else if (pend_reg) begin
      ped_reg      <= 1'b1;
      dir_reg      <= pend_dir_reg;
      pend_reg     <= single_evt;
      pend_dir_reg <= single_dir;
    end else if (single_evt) begin
      ped_reg <= 1'b1;
      dir_reg <= single_dir;
    end
  end

  assign PED    = ped_reg;
  assign uphdnl = dir_reg;

endmodule
